// File: rtl/game_session_ctl.sv
// Round controller for an N-player game: countdown/play timer, saturating
// per-player scores, car/gremlin enables and end-of-round winner/tie latch.
module game_session_ctl #(
   parameter int NUM_PLAYERS       = 2,
   parameter int SCORE_W           = 8,
   parameter int FRAMES_PER_SEC    = 60,
   parameter int GAME_SECONDS      = 60,
   parameter int COUNTDOWN_SECONDS = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_tick,
   input  logic                           start,
   input  logic                           pause,
   input  logic [3:0]                     num_players,
   input  logic [NUM_PLAYERS-1:0]         hit,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [7:0]                     time_left,
   output logic [NUM_PLAYERS-1:0]         car_enable,
   output logic                           gremlins_enable,
   output logic                           countdown,
   output logic                           time_out,
   output logic [2:0]                     winner,
   output logic                           tie,
   output logic [NUM_PLAYERS-1:0]         active
);

   localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FC_W-1:0]    FC_LOAD   = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [FC_W-1:0]    FC_ZERO   = {FC_W{1'b0}};
   localparam logic [FC_W-1:0]    FC_ONE    = FC_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSED    = 3'd3,
      ST_OVER      = 3'd4
   } state_t;

   state_t                 state_r;
   logic [FC_W-1:0]        frame_cnt_r;
   logic [SCORE_W-1:0]     score_r     [NUM_PLAYERS];
   logic [SCORE_W-1:0]     score_nxt_s [NUM_PLAYERS];
   logic [7:0]             time_left_r;
   logic [NUM_PLAYERS-1:0] car_enable_r;
   logic                   gremlins_enable_r;
   logic                   countdown_r;
   logic                   time_out_r;
   logic [2:0]             winner_r;
   logic                   tie_r;
   logic [NUM_PLAYERS-1:0] active_r;

   logic [3:0]             n_s;
   logic [NUM_PLAYERS-1:0] new_mask_s;
   logic [SCORE_W-1:0]     best_s;
   logic                   found_s;
   logic [2:0]             winner_s;
   logic                   tie_s;
   logic                   play_end_s;

   // Clamp the requested player count and build the active mask for a new round
   always_comb begin
      n_s = num_players;
      if (num_players == 4'd0) begin
         n_s = 4'd1;
      end else if (num_players > 4'(NUM_PLAYERS)) begin
         n_s = 4'(NUM_PLAYERS);
      end else begin
         n_s = num_players;
      end
      new_mask_s = {NUM_PLAYERS{1'b0}};
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         new_mask_s[i] = (4'(i) < n_s);
      end
   end

   // Post-hit scores, and winner/tie ranked on those so a hit on the final tick counts
   always_comb begin
      best_s   = {SCORE_W{1'b0}};
      found_s  = 1'b0;
      winner_s = 3'd0;
      tie_s    = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if ((state_r == ST_PLAY) && active_r[i] && hit[i] && (score_r[i] != SCORE_MAX)) begin
            score_nxt_s[i] = score_r[i] + SCORE_ONE;
         end else begin
            score_nxt_s[i] = score_r[i];
         end
         if (active_r[i]) begin
            if (!found_s || (score_nxt_s[i] > best_s)) begin
               best_s   = score_nxt_s[i];
               winner_s = 3'(i);
               tie_s    = 1'b0;
               found_s  = 1'b1;
            end else if (score_nxt_s[i] == best_s) begin
               tie_s = 1'b1;
            end else begin
               tie_s = tie_s;
            end
         end else begin
            tie_s = tie_s;
         end
      end
      play_end_s = frame_tick && (frame_cnt_r == FC_ZERO) && (time_left_r == 8'd1);
   end

   // Session state machine with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= ST_IDLE;
         frame_cnt_r       <= FC_ZERO;
         time_left_r       <= 8'd0;
         car_enable_r      <= {NUM_PLAYERS{1'b0}};
         gremlins_enable_r <= 1'b0;
         countdown_r       <= 1'b0;
         time_out_r        <= 1'b0;
         winner_r          <= 3'd0;
         tie_r             <= 1'b0;
         active_r          <= {NUM_PLAYERS{1'b0}};
         for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= {SCORE_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  active_r     <= new_mask_s;
                  car_enable_r <= new_mask_s;
                  winner_r     <= 3'd0;
                  tie_r        <= 1'b0;
                  time_out_r   <= 1'b0;
                  frame_cnt_r  <= FC_LOAD;
                  for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= {SCORE_W{1'b0}};
                  if (COUNTDOWN_SECONDS == 0) begin
                     state_r           <= ST_PLAY;
                     time_left_r       <= 8'(GAME_SECONDS);
                     gremlins_enable_r <= 1'b1;
                     countdown_r       <= 1'b0;
                  end else begin
                     state_r           <= ST_COUNTDOWN;
                     time_left_r       <= 8'(COUNTDOWN_SECONDS);
                     gremlins_enable_r <= 1'b0;
                     countdown_r       <= 1'b1;
                  end
               end
            end
            ST_COUNTDOWN: begin
               if (frame_tick) begin
                  if (frame_cnt_r != FC_ZERO) begin
                     frame_cnt_r <= frame_cnt_r - FC_ONE;
                  end else begin
                     frame_cnt_r <= FC_LOAD;
                     if (time_left_r == 8'd1) begin
                        state_r           <= ST_PLAY;
                        time_left_r       <= 8'(GAME_SECONDS);
                        countdown_r       <= 1'b0;
                        gremlins_enable_r <= 1'b1;
                     end else begin
                        time_left_r <= time_left_r - 8'd1;
                     end
                  end
               end
            end
            ST_PLAY: begin
               score_r <= score_nxt_s;
               if (frame_tick) begin
                  if (frame_cnt_r != FC_ZERO) begin
                     frame_cnt_r <= frame_cnt_r - FC_ONE;
                  end else begin
                     frame_cnt_r <= FC_LOAD;
                     time_left_r <= time_left_r - 8'd1;
                  end
               end
               // Round expiry wins over a pause request on the same cycle
               if (play_end_s) begin
                  state_r           <= ST_OVER;
                  winner_r          <= winner_s;
                  tie_r             <= tie_s;
                  car_enable_r      <= {NUM_PLAYERS{1'b0}};
                  gremlins_enable_r <= 1'b0;
                  time_out_r        <= 1'b1;
               end else if (pause) begin
                  state_r           <= ST_PAUSED;
                  car_enable_r      <= {NUM_PLAYERS{1'b0}};
                  gremlins_enable_r <= 1'b0;
               end
            end
            ST_PAUSED: begin
               if (!pause) begin
                  state_r           <= ST_PLAY;
                  car_enable_r      <= active_r;
                  gremlins_enable_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
      assign scores[g*SCORE_W +: SCORE_W] = score_r[g];
   end

   assign time_left       = time_left_r;
   assign car_enable      = car_enable_r;
   assign gremlins_enable = gremlins_enable_r;
   assign countdown       = countdown_r;
   assign time_out        = time_out_r;
   assign winner          = winner_r;
   assign tie             = tie_r;
   assign active          = active_r;

endmodule

// File: tb/tb_game_session_ctl.sv
// Directed bench for game_session_ctl: a wide-score and a 2-bit-score instance share stimulus.
module tb_game_session_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  num_players = 4'd2;
   logic [1:0]  hit = 2'b00;

   logic [15:0] scores;
   logic [7:0]  time_left;
   logic [1:0]  car_enable;
   logic        gremlins_enable, countdown, time_out, tie;
   logic [2:0]  winner;
   logic [1:0]  active;

   logic [3:0]  s_scores;
   logic [7:0]  s_time_left;
   logic [1:0]  s_car_enable;
   logic        s_gremlins_enable, s_countdown, s_time_out, s_tie;
   logic [2:0]  s_winner;
   logic [1:0]  s_active;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_session_ctl #(.NUM_PLAYERS(2), .SCORE_W(8), .FRAMES_PER_SEC(2),
                      .GAME_SECONDS(3), .COUNTDOWN_SECONDS(2)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
      .num_players(num_players), .hit(hit), .scores(scores), .time_left(time_left),
      .car_enable(car_enable), .gremlins_enable(gremlins_enable), .countdown(countdown),
      .time_out(time_out), .winner(winner), .tie(tie), .active(active));

   game_session_ctl #(.NUM_PLAYERS(2), .SCORE_W(2), .FRAMES_PER_SEC(2),
                      .GAME_SECONDS(3), .COUNTDOWN_SECONDS(2)) dut_s (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
      .num_players(num_players), .hit(hit), .scores(s_scores), .time_left(s_time_left),
      .car_enable(s_car_enable), .gremlins_enable(s_gremlins_enable), .countdown(s_countdown),
      .time_out(s_time_out), .winner(s_winner), .tie(s_tie), .active(s_active));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_hit(input logic [1:0] h, input int k);
      for (int i = 0; i < k; i++) begin
         hit = h;
         cyc();
         hit = 2'b00;
      end
   endtask

   task automatic start_round(input logic [3:0] n);
      num_players = n;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      hit = 2'b11;
      for (int i = 0; i < 4; i++) begin
         frame_tick = 1'b1;
         cyc();
      end
      frame_tick = 1'b0;
      hit = 2'b00;
      cyc();
      n_checks++; if (scores !== 16'h0000) begin n_fail++; $display("FAIL reset_scores: got %h exp 0000", scores); end
      n_checks++; if (s_scores !== 4'h0) begin n_fail++; $display("FAIL reset_scores_small: got %h exp 0", s_scores); end
      n_checks++; if (time_left !== 8'd0) begin n_fail++; $display("FAIL reset_time_left: got %0d exp 0", time_left); end
      n_checks++; if (car_enable !== 2'b00) begin n_fail++; $display("FAIL reset_car_enable: got %b exp 00", car_enable); end
      n_checks++; if ({gremlins_enable, countdown, time_out, tie} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {gremlins_enable, countdown, time_out, tie}); end
      n_checks++; if (winner !== 3'd0) begin n_fail++; $display("FAIL reset_winner: got %0d exp 0", winner); end
      n_checks++; if (active !== 2'b00) begin n_fail++; $display("FAIL reset_active: got %b exp 00", active); end
   endtask

   task automatic test_full_round();
      start_round(4'd2);
      n_checks++; if (countdown !== 1'b1) begin n_fail++; $display("FAIL round_countdown_on: got %b exp 1", countdown); end
      n_checks++; if (car_enable !== 2'b11) begin n_fail++; $display("FAIL round_car_enable: got %b exp 11", car_enable); end
      n_checks++; if (time_left !== 8'd2) begin n_fail++; $display("FAIL round_cd_time: got %0d exp 2", time_left); end
      n_checks++; if (gremlins_enable !== 1'b0) begin n_fail++; $display("FAIL round_cd_gremlins: got %b exp 0", gremlins_enable); end
      ticks(3);
      n_checks++; if ({countdown, time_left} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL round_cd_3ticks: got %b/%0d exp 1/1", countdown, time_left); end
      ticks(1);
      n_checks++; if ({countdown, gremlins_enable, time_left} !== {1'b0, 1'b1, 8'd3}) begin n_fail++; $display("FAIL round_play_entry: got %b/%b/%0d exp 0/1/3", countdown, gremlins_enable, time_left); end
      ticks(5);
      n_checks++; if ({time_out, time_left} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL round_play_5ticks: got %b/%0d exp 0/1", time_out, time_left); end
      ticks(1);
      n_checks++; if ({time_out, time_left} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL round_over: got %b/%0d exp 1/0", time_out, time_left); end
      n_checks++; if ({car_enable, gremlins_enable} !== 3'b000) begin n_fail++; $display("FAIL round_over_enables: got %b exp 000", {car_enable, gremlins_enable}); end
      n_checks++; if ({winner, tie} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL round_zero_tie: got %0d/%b exp 0/1", winner, tie); end
   endtask

   task automatic test_scoring();
      start_round(4'd2);
      pulse_hit(2'b01, 2);
      ticks(4);
      pulse_hit(2'b01, 5);
      pulse_hit(2'b10, 3);
      pulse_hit(2'b11, 1);
      n_checks++; if (scores !== {8'd4, 8'd6}) begin n_fail++; $display("FAIL score_6_4: got %h exp 0406", scores); end
      n_checks++; if (s_scores !== {2'd3, 2'd3}) begin n_fail++; $display("FAIL score_saturate: got %h exp f", s_scores); end
      ticks(6);
      n_checks++; if ({time_out, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin n_fail++; $display("FAIL score_winner: got %b/%0d/%b exp 1/0/0", time_out, winner, tie); end
      n_checks++; if ({s_winner, s_tie} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL score_sat_tie: got %0d/%b exp 0/1", s_winner, s_tie); end
      pulse_hit(2'b11, 2);
      start = 1'b0;
      n_checks++; if (scores !== {8'd4, 8'd6}) begin n_fail++; $display("FAIL score_hold_over: got %h exp 0406", scores); end
   endtask

   task automatic test_single_clamp();
      start_round(4'd1);
      n_checks++; if ({active, car_enable} !== 4'b0101) begin n_fail++; $display("FAIL single_masks: got %b exp 0101", {active, car_enable}); end
      n_checks++; if (scores !== 16'h0000) begin n_fail++; $display("FAIL single_cleared: got %h exp 0000", scores); end
      ticks(4);
      pulse_hit(2'b10, 2);
      pulse_hit(2'b01, 1);
      n_checks++; if (scores !== {8'd0, 8'd1}) begin n_fail++; $display("FAIL single_hits: got %h exp 0001", scores); end
      n_checks++; if (car_enable !== 2'b01) begin n_fail++; $display("FAIL single_play_car: got %b exp 01", car_enable); end
      ticks(6);
      n_checks++; if ({time_out, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin n_fail++; $display("FAIL single_over: got %b/%0d/%b exp 1/0/0", time_out, winner, tie); end
      start_round(4'd9);
      n_checks++; if ({active, car_enable} !== 4'b1111) begin n_fail++; $display("FAIL clamp_9: got %b exp 1111", {active, car_enable}); end
      ticks(10);
   endtask

   task automatic test_pause_tie();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      n_checks++; if ({time_out, gremlins_enable} !== 2'b10) begin n_fail++; $display("FAIL pause_in_over: got %b exp 10", {time_out, gremlins_enable}); end
      start_round(4'd2);
      ticks(5);
      pause = 1'b1;
      cyc();
      n_checks++; if ({car_enable, gremlins_enable} !== 3'b000) begin n_fail++; $display("FAIL paused_enables: got %b exp 000", {car_enable, gremlins_enable}); end
      hit = 2'b11;
      ticks(10);
      hit = 2'b00;
      n_checks++; if ({time_left, scores} !== {8'd3, 16'h0000}) begin n_fail++; $display("FAIL paused_hold: got %0d/%h exp 3/0000", time_left, scores); end
      pause = 1'b0;
      cyc();
      n_checks++; if ({car_enable, gremlins_enable} !== 3'b111) begin n_fail++; $display("FAIL resume_enables: got %b exp 111", {car_enable, gremlins_enable}); end
      ticks(1);
      n_checks++; if (time_left !== 8'd2) begin n_fail++; $display("FAIL resume_frame_cnt: got %0d exp 2", time_left); end
      pulse_hit(2'b11, 2);
      ticks(4);
      n_checks++; if ({time_out, scores, winner, tie} !== {1'b1, 8'd2, 8'd2, 3'd0, 1'b1}) begin n_fail++; $display("FAIL tie_2_2: got %b/%h/%0d/%b exp 1/0202/0/1", time_out, scores, winner, tie); end
   endtask

   task automatic test_final_tick();
      start_round(4'd2);
      ticks(4);
      pulse_hit(2'b11, 2);
      ticks(5);
      n_checks++; if ({time_out, time_left} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL final_pre: got %b/%0d exp 0/1", time_out, time_left); end
      frame_tick = 1'b1;
      hit = 2'b10;
      cyc();
      frame_tick = 1'b0;
      hit = 2'b00;
      n_checks++; if ({time_out, scores} !== {1'b1, 8'd3, 8'd2}) begin n_fail++; $display("FAIL final_hit_counted: got %b/%h exp 1/0302", time_out, scores); end
      n_checks++; if ({winner, tie} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL final_winner: got %0d/%b exp 1/0", winner, tie); end
   endtask

   task automatic test_restart_reset();
      start_round(4'd2);
      n_checks++; if ({scores, countdown, time_out, winner, tie} !== {16'h0000, 1'b1, 1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL restart: got %h/%b/%b/%0d/%b exp 0000/1/0/0/0", scores, countdown, time_out, winner, tie); end
      ticks(1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      ticks(1);
      n_checks++; if ({countdown, time_left} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL start_ignored: got %b/%0d exp 1/1", countdown, time_left); end
      ticks(2);
      pulse_hit(2'b01, 1);
      n_checks++; if ({gremlins_enable, scores} !== {1'b1, 16'h0001}) begin n_fail++; $display("FAIL pre_reset_play: got %b/%h exp 1/0001", gremlins_enable, scores); end
      hit = 2'b01;
      frame_tick = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      hit = 2'b00;
      frame_tick = 1'b0;
      n_checks++; if ({scores, time_left, car_enable, active} !== {16'h0000, 8'd0, 2'b00, 2'b00}) begin n_fail++; $display("FAIL midround_reset: got %h/%0d/%b/%b exp 0000/0/00/00", scores, time_left, car_enable, active); end
      n_checks++; if ({gremlins_enable, countdown, time_out, winner, tie} !== 7'b0) begin n_fail++; $display("FAIL midround_reset_flags: got %b exp 0000000", {gremlins_enable, countdown, time_out, winner, tie}); end
      ticks(3);
      n_checks++; if ({countdown, gremlins_enable, time_left} !== 10'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b/%b/%0d exp 0/0/0", countdown, gremlins_enable, time_left); end
   endtask

   initial begin
      test_reset();
      test_full_round();
      test_scoring();
      test_single_clamp();
      test_pause_tie();
      test_final_tick();
      test_restart_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
